// File: rtl/sys_ctrl_burst_if.sv
// sys_ctrl_burst_if: bundles every non-clock/reset signal of sys_ctrl_burst.
//   master : the controller side (drives strobes, address, write data, TX push, CMD_ERR)
//   slave  : the environment side (RX byte stream, register file, ALU, TX FIFO status)
// Signal summary (direction seen from the master):
//   RX_P_Data/RX_Data_Valid   in   framed command byte stream
//   RdData/RdData_Valid       in   register file read return
//   ALU_OUT/ALU_OUT_Valid     in   ALU result return
//   TX_Busy                   in   TX FIFO full
//   ALU_EN/ALU_FUN/ALU_CLK_EN out  ALU control
//   Address/WrEN/RdEN/WrData  out  register file access
//   TX_P_Data/TX_Data_Valid   out  TX FIFO push
//   clk_div_en                out  UART clock divider enable
//   CMD_ERR                   out  illegal frame / dropped byte pulse
interface sys_ctrl_burst_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_FUN_WIDTH = 4,
    parameter int unsigned ALU_OUT_BYTES = 2
) ();
    logic [DATA_WIDTH-1:0]               RX_P_Data;
    logic                                RX_Data_Valid;
    logic [DATA_WIDTH-1:0]               RdData;
    logic                                RdData_Valid;
    logic [ALU_OUT_BYTES*DATA_WIDTH-1:0] ALU_OUT;
    logic                                ALU_OUT_Valid;
    logic                                TX_Busy;
    logic                                ALU_EN;
    logic [ALU_FUN_WIDTH-1:0]            ALU_FUN;
    logic                                ALU_CLK_EN;
    logic [ADDR_WIDTH-1:0]               Address;
    logic                                WrEN;
    logic                                RdEN;
    logic [DATA_WIDTH-1:0]               WrData;
    logic [DATA_WIDTH-1:0]               TX_P_Data;
    logic                                TX_Data_Valid;
    logic                                clk_div_en;
    logic                                CMD_ERR;

    modport master (
        input  RX_P_Data, RX_Data_Valid, RdData, RdData_Valid, ALU_OUT, ALU_OUT_Valid, TX_Busy,
        output ALU_EN, ALU_FUN, ALU_CLK_EN, Address, WrEN, RdEN, WrData, TX_P_Data,
               TX_Data_Valid, clk_div_en, CMD_ERR
    );

    modport slave (
        output RX_P_Data, RX_Data_Valid, RdData, RdData_Valid, ALU_OUT, ALU_OUT_Valid, TX_Busy,
        input  ALU_EN, ALU_FUN, ALU_CLK_EN, Address, WrEN, RdEN, WrData, TX_P_Data,
               TX_Data_Valid, clk_div_en, CMD_ERR
    );
endinterface

// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: system controller between the UART RX/TX paths, register file and ALU.
// Parses framed commands from the RX byte stream, issues register/ALU strobes and queues
// response bytes into the TX FIFO. Supports single and burst register access, multi-byte ALU
// result streaming (LSB byte first), TX back-pressure and CMD_ERR on illegal frames.
// Ports:
//   CLK  in  system clock
//   RST  in  asynchronous active-low reset
//   bus  sys_ctrl_burst_if.master (RX stream, register file, ALU, TX FIFO, CMD_ERR)
module sys_ctrl_burst #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_FUN_WIDTH = 4,
    parameter int unsigned ALU_OUT_BYTES = 2
) (
    input logic              CLK,
    input logic              RST,
    sys_ctrl_burst_if.master bus
);
    localparam int unsigned AluOutW = ALU_OUT_BYTES * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] CmdWr   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRd   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAlu  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAluF = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] CmdBwr  = DATA_WIDTH'(8'hEE);
    localparam logic [DATA_WIDTH-1:0] CmdBrd  = DATA_WIDTH'(8'hFF);

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StAluA,
        StAluB,
        StAluFun,
        StBurstAddr,
        StBurstLen,
        StBurstData,
        StRdWait,
        StAluWait,
        StTxPush
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;         // current (burst) address
    logic [DATA_WIDTH-1:0]   len_q, len_d;           // remaining beats / bytes
    logic                    burst_wr_q, burst_wr_d;
    logic                    src_alu_q, src_alu_d;   // TX byte comes from ALU (else read)
    logic [AluOutW-1:0]      alu_res_q, alu_res_d;   // not-yet-sent ALU result bytes
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;

    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    alu_en_q, alu_en_d;
    logic                    alu_clk_en_q, alu_clk_en_d;
    logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    cmd_err_q, cmd_err_d;
    logic                    tx_valid;

    logic [DATA_WIDTH-1:0]   rx_byte;
    logic                    rx_valid;

    assign rx_byte  = bus.RX_P_Data;
    assign rx_valid = bus.RX_Data_Valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            len_q        <= '0;
            burst_wr_q   <= 1'b0;
            src_alu_q    <= 1'b0;
            alu_res_q    <= '0;
            tx_data_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            alu_clk_en_q <= 1'b0;
            alu_fun_q    <= '0;
            address_q    <= '0;
            wr_data_q    <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            burst_wr_q   <= burst_wr_d;
            src_alu_q    <= src_alu_d;
            alu_res_q    <= alu_res_d;
            tx_data_q    <= tx_data_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            alu_en_q     <= alu_en_d;
            alu_clk_en_q <= alu_clk_en_d;
            alu_fun_q    <= alu_fun_d;
            address_q    <= address_d;
            wr_data_q    <= wr_data_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        burst_wr_d   = burst_wr_q;
        src_alu_d    = src_alu_q;
        alu_res_d    = alu_res_q;
        tx_data_d    = tx_data_q;
        alu_clk_en_d = alu_clk_en_q;
        alu_fun_d    = alu_fun_q;
        address_d    = address_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        alu_en_d     = 1'b0;
        cmd_err_d    = 1'b0;
        tx_valid     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    case (rx_byte)
                        CmdWr:   state_d = StWrAddr;
                        CmdRd:   state_d = StRdAddr;
                        CmdAlu:  state_d = StAluA;
                        CmdAluF: state_d = StAluFun;
                        CmdBwr: begin
                            burst_wr_d = 1'b1;
                            state_d    = StBurstAddr;
                        end
                        CmdBrd: begin
                            burst_wr_d = 1'b0;
                            state_d    = StBurstAddr;
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            StWrAddr: begin
                if (rx_valid) begin
                    addr_d  = rx_byte[ADDR_WIDTH-1:0];
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wr_data_d = rx_byte;
                    state_d   = StIdle;
                end
            end
            StRdAddr: begin
                if (rx_valid) begin
                    addr_d    = rx_byte[ADDR_WIDTH-1:0];
                    address_d = rx_byte[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    len_d     = DATA_WIDTH'(1);
                    state_d   = StRdWait;
                end
            end
            // Operands land in registers 0 and 1 where the ALU reads them.
            StAluA: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_WIDTH'(0);
                    wr_data_d = rx_byte;
                    state_d   = StAluB;
                end
            end
            StAluB: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_WIDTH'(1);
                    wr_data_d = rx_byte;
                    state_d   = StAluFun;
                end
            end
            StAluFun: begin
                if (rx_valid) begin
                    alu_en_d     = 1'b1;
                    alu_clk_en_d = 1'b1;
                    alu_fun_d    = rx_byte[ALU_FUN_WIDTH-1:0];
                    state_d      = StAluWait;
                end
            end
            StBurstAddr: begin
                if (rx_valid) begin
                    addr_d  = rx_byte[ADDR_WIDTH-1:0];
                    state_d = StBurstLen;
                end
            end
            StBurstLen: begin
                if (rx_valid) begin
                    if (rx_byte == '0) begin
                        cmd_err_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        len_d = rx_byte;
                        if (burst_wr_q) begin
                            state_d = StBurstData;
                        end else begin
                            rd_en_d   = 1'b1;
                            address_d = addr_q;
                            state_d   = StRdWait;
                        end
                    end
                end
            end
            StBurstData: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wr_data_d = rx_byte;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    len_d     = len_q - DATA_WIDTH'(1);
                    if (len_q == DATA_WIDTH'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            // Waiting states cannot accept a frame byte: drop it and flag it.
            StRdWait: begin
                if (rx_valid) begin
                    cmd_err_d = 1'b1;
                end
                if (bus.RdData_Valid) begin
                    tx_data_d = bus.RdData;
                    len_d     = len_q - DATA_WIDTH'(1);
                    src_alu_d = 1'b0;
                    state_d   = StTxPush;
                end
            end
            StAluWait: begin
                if (rx_valid) begin
                    cmd_err_d = 1'b1;
                end
                if (bus.ALU_OUT_Valid) begin
                    alu_clk_en_d = 1'b0;
                    tx_data_d    = bus.ALU_OUT[DATA_WIDTH-1:0];
                    alu_res_d    = bus.ALU_OUT >> DATA_WIDTH;
                    len_d        = DATA_WIDTH'(ALU_OUT_BYTES - 1);
                    src_alu_d    = 1'b1;
                    state_d      = StTxPush;
                end
            end
            // tx_data_q is held until the push is accepted; len_q counts what follows it.
            StTxPush: begin
                if (rx_valid) begin
                    cmd_err_d = 1'b1;
                end
                if (!bus.TX_Busy) begin
                    tx_valid = 1'b1;
                    if (len_q == '0) begin
                        state_d = StIdle;
                    end else if (src_alu_q) begin
                        tx_data_d = alu_res_q[DATA_WIDTH-1:0];
                        alu_res_d = alu_res_q >> DATA_WIDTH;
                        len_d     = len_q - DATA_WIDTH'(1);
                    end else begin
                        addr_d    = addr_q + ADDR_WIDTH'(1);
                        address_d = addr_q + ADDR_WIDTH'(1);
                        rd_en_d   = 1'b1;
                        state_d   = StRdWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.ALU_EN        = alu_en_q;
    assign bus.ALU_FUN       = alu_fun_q;
    assign bus.ALU_CLK_EN    = alu_clk_en_q;
    assign bus.Address       = address_q;
    assign bus.WrEN          = wr_en_q;
    assign bus.RdEN          = rd_en_q;
    assign bus.WrData        = wr_data_q;
    assign bus.TX_P_Data     = tx_data_q;
    assign bus.TX_Data_Valid = tx_valid;
    assign bus.clk_div_en    = 1'b1;
    assign bus.CMD_ERR       = cmd_err_q;
endmodule

// File: tb/tb_sys_ctrl_burst.sv
// tb_sys_ctrl_burst: directed scoreboard bench for sys_ctrl_burst. Expected strobe/TX events
// are queued per kind as stimulus is issued; a negedge monitor pops and compares them.
module tb_sys_ctrl_burst;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned FW = 4;
    localparam int unsigned OB = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    sys_ctrl_burst_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(FW), .ALU_OUT_BYTES(OB)
    ) bus ();

    sys_ctrl_burst #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(FW), .ALU_OUT_BYTES(OB)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rx_cyc = 0;

    logic [15:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] alu_q[$];
    logic [15:0] tx_q[$];
    logic [15:0] err_q[$];

    logic [7:0] mem [16];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got event %0h, expected none (cycle %0d)", name, act, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (bus.WrEN) begin
            check("wr_latency", cyc, rx_cyc);
            if (wr_q.size() == 0) unexpected("wr", {20'h0, bus.Address, bus.WrData});
            else check("wr", {20'h0, bus.Address, bus.WrData}, {16'h0, wr_q.pop_front()});
        end
        if (bus.RdEN) begin
            if (rd_q.size() == 0) unexpected("rd", {28'h0, bus.Address});
            else check("rd", {28'h0, bus.Address}, {16'h0, rd_q.pop_front()});
        end
        if (bus.ALU_EN) begin
            check("alu_clk_en_start", {31'h0, bus.ALU_CLK_EN}, 1);
            if (alu_q.size() == 0) unexpected("alu", {28'h0, bus.ALU_FUN});
            else check("alu", {28'h0, bus.ALU_FUN}, {16'h0, alu_q.pop_front()});
        end
        if (bus.TX_Busy) check("no_push_while_busy", {31'h0, bus.TX_Data_Valid}, 0);
        if (bus.TX_Data_Valid) begin
            if (tx_q.size() == 0) unexpected("tx", {24'h0, bus.TX_P_Data});
            else check("tx", {24'h0, bus.TX_P_Data}, {16'h0, tx_q.pop_front()});
        end
        if (bus.CMD_ERR) begin
            if (err_q.size() == 0) unexpected("cmd_err", 1);
            else check("cmd_err", 1, {16'h0, err_q.pop_front()});
        end
    end

    // Register file model
    initial begin
        logic [3:0] ra;
        bus.RdData = '0;
        bus.RdData_Valid = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        forever begin
            @(negedge CLK);
            if (bus.WrEN) mem[bus.Address] = bus.WrData;
            if (bus.RdEN) begin
                ra = bus.Address;
                @(posedge CLK); #1;
                bus.RdData = mem[ra];
                bus.RdData_Valid = 1'b1;
                @(posedge CLK); #1;
                bus.RdData_Valid = 1'b0;
            end
        end
    end

    // ALU model: FUN 0 = add, FUN 1 = multiply, operands from registers 0/1
    initial begin
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        bus.ALU_OUT = '0;
        bus.ALU_OUT_Valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.ALU_EN) begin
                f = bus.ALU_FUN;
                a = {8'h00, mem[0]};
                b = {8'h00, mem[1]};
                repeat (3) begin
                    @(negedge CLK);
                    check("alu_clk_en_hold", {31'h0, bus.ALU_CLK_EN}, 1);
                end
                @(posedge CLK); #1;
                bus.ALU_OUT = (f == 4'd0) ? a + b : (f == 4'd1) ? a * b : 16'h0;
                bus.ALU_OUT_Valid = 1'b1;
                @(posedge CLK); #1;
                bus.ALU_OUT_Valid = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        bus.RX_P_Data = b;
        bus.RX_Data_Valid = 1'b1;
        rx_cyc = cyc + 1;
        @(posedge CLK); #1;
        bus.RX_Data_Valid = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size() + err_q.size()) != 0
               && n < 400) begin
            @(posedge CLK);
            n++;
        end
        check(name, wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size() + err_q.size(), 0);
        wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); err_q.delete();
        repeat (4) @(posedge CLK);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobes"}, {26'h0, bus.ALU_EN, bus.ALU_CLK_EN, bus.WrEN, bus.RdEN,
                                   bus.TX_Data_Valid, bus.CMD_ERR}, 0);
        check({name, "_fields"}, {4'h0, bus.ALU_FUN, bus.Address, bus.WrData, bus.TX_P_Data}, 0);
        check({name, "_clk_div_en"}, {31'h0, bus.clk_div_en}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RX_P_Data = '0;
        bus.RX_Data_Valid = 1'b0;
        bus.TX_Busy = 1'b0;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        // WR then RD
        wr_q.push_back(16'h053C);
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        rd_q.push_back(16'h0005); tx_q.push_back(16'h003C);
        send_byte(8'hBB); send_byte(8'h05);
        drain("drain_wr_rd");

        // ALU with operands: 0A + 14 = 001E
        wr_q.push_back(16'h000A); wr_q.push_back(16'h0114);
        alu_q.push_back(16'h0000); tx_q.push_back(16'h001E); tx_q.push_back(16'h0000);
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h14); send_byte(8'h00);
        drain("drain_alu");
        @(negedge CLK);
        check("alu_clk_en_released", {31'h0, bus.ALU_CLK_EN}, 0);

        // Burst write with wrap, then burst read back
        wr_q.push_back(16'h0E11); wr_q.push_back(16'h0F22); wr_q.push_back(16'h0033);
        send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        drain("drain_bwr");
        rd_q.push_back(16'h000E); rd_q.push_back(16'h000F); rd_q.push_back(16'h0000);
        tx_q.push_back(16'h0011); tx_q.push_back(16'h0022); tx_q.push_back(16'h0033);
        send_byte(8'hFF); send_byte(8'h0E); send_byte(8'h03);
        drain("drain_brd");

        // FUN-only ALU reusing reg0=33, reg1=14: 33*14 = 03FC, 33+14 = 0047
        alu_q.push_back(16'h0001); tx_q.push_back(16'h00FC); tx_q.push_back(16'h0003);
        send_byte(8'hDD); send_byte(8'h01);
        drain("drain_alu_mul");
        alu_q.push_back(16'h0000); tx_q.push_back(16'h0047); tx_q.push_back(16'h0000);
        send_byte(8'hDD); send_byte(8'h00);
        drain("drain_alu_add");

        // Back-pressure during a burst read, plus a byte dropped while waiting
        rd_q.push_back(16'h000F); rd_q.push_back(16'h0000);
        tx_q.push_back(16'h0022); tx_q.push_back(16'h0033);
        err_q.push_back(16'h0001);
        send_byte(8'hFF); send_byte(8'h0F);
        @(posedge CLK); #1;
        bus.RX_P_Data = 8'h02;
        bus.RX_Data_Valid = 1'b1;
        @(posedge CLK); #1;
        bus.RX_Data_Valid = 1'b0;
        bus.TX_Busy = 1'b1;
        send_byte(8'h77);
        repeat (6) @(posedge CLK);
        #1 bus.TX_Busy = 1'b0;
        drain("drain_backpressure");

        // Illegal command, zero-length burst, then a normal frame
        err_q.push_back(16'h0001);
        send_byte(8'h55);
        drain("drain_err_cmd");
        err_q.push_back(16'h0001);
        send_byte(8'hEE); send_byte(8'h03); send_byte(8'h00);
        drain("drain_err_len0");
        wr_q.push_back(16'h0299);
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h99);
        drain("drain_after_err");

        // Reset in the middle of a burst write
        wr_q.push_back(16'h04AB);
        send_byte(8'hEE); send_byte(8'h04); send_byte(8'h03); send_byte(8'hAB);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("midreset");
        RST = 1'b1;
        wr_q.push_back(16'h075A);
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h5A);
        drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
